// File: rtl/axi4_rd_pkg.sv
// Shared definitions for the AXI4 frame-buffer read engine.
// Contents: read FSM state enum, AXI4 burst/response encodings,
// 4KB page size and the burst length helper.
package axi4_rd_pkg;

  typedef enum logic [1:0] {
    IDLE_S,
    CALC_BURST_S,
    ADDR_S,
    READ_S
  } rd_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam int         PAGE_BYTES     = 4096;

  // Largest legal INCR burst from addr_lo: bounded by the remaining words,
  // the AXI4 limit of 256 beats and the distance to the next 4KB boundary.
  // wb is log2 of the bus width in bytes.
  function automatic logic [8:0] calc_burst_len(input logic [31:0] words_left,
                                                input logic [11:0] addr_lo,
                                                input int          wb);
    logic [12:0] page_bytes;
    logic [31:0] page_words;
    logic [31:0] len;
    page_bytes = 13'(PAGE_BYTES) - {1'b0, addr_lo};
    page_words = 32'(page_bytes) >> wb;
    len = words_left;
    if (len > 32'd256)    len = 32'd256;
    if (len > page_words) len = page_words;
    return len[8:0];
  endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 memory-mapped bus bundle (all five channels).
// Modports: master (drives AW/W/AR, bready, rready), slave (the reverse).
interface axi4_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int ID_WIDTH     = 1,
  parameter int AWUSER_WIDTH = 1,
  parameter int WUSER_WIDTH  = 1,
  parameter int ARUSER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache, awqos, awregion;
  logic [2:0]              awprot;
  logic [AWUSER_WIDTH-1:0] awuser;
  logic                    awvalid, awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic [WUSER_WIDTH-1:0]  wuser;
  logic                    wvalid, wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid, bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache, arqos, arregion;
  logic [2:0]              arprot;
  logic [ARUSER_WIDTH-1:0] aruser;
  logic                    arvalid, arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast, rvalid, rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
           awregion, awuser, awvalid, input awready,
    output wdata, wstrb, wlast, wuser, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
           arregion, aruser, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
           awregion, awuser, awvalid, output awready,
    input  wdata, wstrb, wlast, wuser, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
           arregion, aruser, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with strobe/keep, last and a 1-bit start-of-frame user.
// Modports: master (drives everything but tready), slave (the reverse).
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb, tkeep;
  logic                    tlast, tuser, tvalid, tready;

  modport master (output tdata, tstrb, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tstrb, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/axi4_to_axi4_stream_strb_gen.sv
// Byte strobe decoder for the stream side.
// Ports: last       - current word is the final word of the packet
//        tail_bytes - valid bytes in the final word (0 means the word is full)
//        strb       - all-ones, or the low tail_bytes bits on a partial last word
module axi4_to_axi4_stream_strb_gen #(
  parameter  int BYTES = 8,
  localparam int WB    = $clog2(BYTES)
) (
  input  logic             last,
  input  logic [WB-1:0]    tail_bytes,
  output logic [BYTES-1:0] strb
);

  always_comb begin
    strb = '1;
    if (last && tail_bytes != '0) begin
      for (int i = 0; i < BYTES; i++) begin
        strb[i] = (i < 32'(tail_bytes));
      end
    end
  end

endmodule

// File: rtl/axi4_to_axi4_stream.sv
// Frame-buffer read engine: on start_i, fetches pkt_size_i bytes from addr_i
// with AXI4 INCR bursts (one outstanding, never crossing 4KB) and forwards
// them, unbuffered, as one AXI4-Stream packet.
// Ports: clk_i, rst_i (sync, active high), start_i, pkt_size_i (bytes),
//        addr_i (byte address, aligned down to the bus width), busy_o,
//        err_o (sticky read error), mem_o (AXI4 read master, writes tied off),
//        pkt_o (AXI4-Stream master, tuser marks the first word).
// Build option: define AXI4_TO_AXI4_STREAM_RRESP_CHK_EN to enable the
// rresp / rlast cross-check driving err_o; otherwise err_o is constant 0.
module axi4_to_axi4_stream
  import axi4_rd_pkg::*;
#(
  parameter int DATA_WIDTH         = 64,
  parameter int ADDR_WIDTH         = 32,
  parameter int ID_WIDTH           = 1,
  parameter int AWUSER_WIDTH       = 1,
  parameter int WUSER_WIDTH        = 1,
  parameter int ARUSER_WIDTH       = 1,
  parameter int MAX_PKT_SIZE_B     = 2048,
  parameter int MAX_PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B * 4)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [MAX_PKT_SIZE_WIDTH:0] pkt_size_i,
  input  logic [ADDR_WIDTH-1:0]       addr_i,
  output logic                        busy_o,
  output logic                        err_o,
  axi4_if.master                      mem_o,
  axi4_stream_if.master               pkt_o
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int WB     = $clog2(BYTES);
  localparam int SIZE_W = MAX_PKT_SIZE_WIDTH + 1;
  localparam int WL_W   = SIZE_W - WB + 1;

  rd_state_t             state;
  logic [ADDR_WIDTH-1:0] cur_addr, araddr;
  logic [WL_W-1:0]       words_left, start_words;
  logic [WB-1:0]         tail_bytes;
  logic [7:0]            arlen, burst_left;
  logic [8:0]            burst_len;
  logic                  arvalid, first_word;
  logic                  in_read, beat, burst_end, last_word, start_ok;
  logic [BYTES-1:0]      strb;

  assign start_words = WL_W'(pkt_size_i[SIZE_W-1:WB]) + WL_W'(|pkt_size_i[WB-1:0]);
  assign burst_len   = calc_burst_len(32'(words_left), cur_addr[11:0], WB);
  assign start_ok    = (state == IDLE_S) && start_i && (pkt_size_i != '0);
  assign in_read     = (state == READ_S);
  assign beat        = in_read && mem_o.rvalid && pkt_o.tready;
  assign burst_end   = mem_o.rlast || (burst_left == 8'd0);
  assign last_word   = (words_left == WL_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE_S;
      cur_addr   <= '0;
      araddr     <= '0;
      words_left <= '0;
      tail_bytes <= '0;
      arlen      <= '0;
      burst_left <= '0;
      arvalid    <= 1'b0;
      busy_o     <= 1'b0;
      first_word <= 1'b0;
    end else begin
      case (state)
        IDLE_S: begin
          if (start_ok) begin
            cur_addr   <= {addr_i[ADDR_WIDTH-1:WB], {WB{1'b0}}};
            words_left <= start_words;
            tail_bytes <= pkt_size_i[WB-1:0];
            first_word <= 1'b1;
            busy_o     <= 1'b1;
            state      <= CALC_BURST_S;
          end
        end
        CALC_BURST_S: begin
          araddr     <= cur_addr;
          arlen      <= 8'(burst_len - 9'd1);
          burst_left <= 8'(burst_len - 9'd1);
          arvalid    <= 1'b1;
          state      <= ADDR_S;
        end
        ADDR_S: begin
          if (mem_o.arready) begin
            arvalid <= 1'b0;
            state   <= READ_S;
          end
        end
        READ_S: begin
          if (beat) begin
            words_left <= words_left - WL_W'(1);
            burst_left <= burst_left - 8'd1;
            cur_addr   <= cur_addr + ADDR_WIDTH'(BYTES);
            first_word <= 1'b0;
            // rlast drives progress; burst_left only backs it up.
            if (burst_end) begin
              if (last_word) begin
                busy_o <= 1'b0;
                state  <= IDLE_S;
              end else begin
                state  <= CALC_BURST_S;
              end
            end
          end
        end
        default: state <= IDLE_S;
      endcase
    end
  end

`ifdef AXI4_TO_AXI4_STREAM_RRESP_CHK_EN
  // Sticky until the next accepted start; data keeps flowing regardless.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (start_ok) begin
      err_o <= 1'b0;
    end else if (beat && (mem_o.rresp != RESP_OKAY ||
                          (mem_o.rlast && burst_left != 8'd0))) begin
      err_o <= 1'b1;
    end
  end
  logic unused_inputs;
  assign unused_inputs = ^{mem_o.awready, mem_o.wready, mem_o.bvalid, mem_o.bresp,
                           mem_o.bid, mem_o.rid, addr_i[WB-1:0]};
`else
  assign err_o = 1'b0;
  logic unused_inputs;
  assign unused_inputs = ^{mem_o.awready, mem_o.wready, mem_o.bvalid, mem_o.bresp,
                           mem_o.bid, mem_o.rid, mem_o.rresp, addr_i[WB-1:0]};
`endif

  axi4_to_axi4_stream_strb_gen #(.BYTES(BYTES)) u_strb_gen (
    .last       (last_word),
    .tail_bytes (tail_bytes),
    .strb       (strb)
  );

  // Read address channel.
  assign mem_o.arvalid  = arvalid;
  assign mem_o.araddr   = araddr;
  assign mem_o.arlen    = arlen;
  assign mem_o.arsize   = 3'(WB);
  assign mem_o.arburst  = AXI_BURST_INCR;
  assign mem_o.arid     = {ID_WIDTH{1'b0}};
  assign mem_o.arlock   = 1'b0;
  assign mem_o.arcache  = 4'd0;
  assign mem_o.arprot   = 3'd0;
  assign mem_o.arqos    = 4'd0;
  assign mem_o.arregion = 4'd0;
  assign mem_o.aruser   = {ARUSER_WIDTH{1'b0}};

  // Read data passes straight through; stream backpressure stalls R.
  assign mem_o.rready = in_read && pkt_o.tready;
  assign pkt_o.tvalid = in_read && mem_o.rvalid;
  assign pkt_o.tdata  = mem_o.rdata;
  assign pkt_o.tlast  = in_read && last_word;
  assign pkt_o.tuser  = first_word;
  assign pkt_o.tstrb  = strb;
  assign pkt_o.tkeep  = strb;

  // Write side is never used.
  assign mem_o.awvalid  = 1'b0;
  assign mem_o.awid     = {ID_WIDTH{1'b0}};
  assign mem_o.awaddr   = '0;
  assign mem_o.awlen    = 8'd0;
  assign mem_o.awsize   = 3'd0;
  assign mem_o.awburst  = 2'd0;
  assign mem_o.awlock   = 1'b0;
  assign mem_o.awcache  = 4'd0;
  assign mem_o.awprot   = 3'd0;
  assign mem_o.awqos    = 4'd0;
  assign mem_o.awregion = 4'd0;
  assign mem_o.awuser   = {AWUSER_WIDTH{1'b0}};
  assign mem_o.wvalid   = 1'b0;
  assign mem_o.wdata    = '0;
  assign mem_o.wstrb    = '0;
  assign mem_o.wlast    = 1'b0;
  assign mem_o.wuser    = {WUSER_WIDTH{1'b0}};
  assign mem_o.bready   = 1'b1;

endmodule

// File: tb/tb_axi4_to_axi4_stream.sv
// Testbench for axi4_to_axi4_stream: AXI4 read slave model with a
// synthetic memory, expected AR and stream beats queued at stimulus time,
// and a monitor that pops and compares on every handshake.
module tb_axi4_to_axi4_stream;

  localparam int DW = 64;
  localparam int AW = 32;
`ifdef AXI4_TO_AXI4_STREAM_RRESP_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] pkt_size;
  logic [31:0] addr;
  logic        busy, err;

  always #5 clk = ~clk;

  axi4_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();
  axi4_stream_if #(.DATA_WIDTH(DW)) pkt ();

  axi4_to_axi4_stream #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(1), .AWUSER_WIDTH(1),
    .WUSER_WIDTH(1), .ARUSER_WIDTH(1), .MAX_PKT_SIZE_B(2048), .MAX_PKT_SIZE_WIDTH(13)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .pkt_size_i (pkt_size),
    .addr_i     (addr),
    .busy_o     (busy),
    .err_o      (err),
    .mem_o      (mem),
    .pkt_o      (pkt)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  beat_t beat_q[$];
  ar_t   ar_q[$];

  int          checks = 0;
  int          errors = 0;
  int          tready_duty = 100;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  bit          exp_err = 1'b0;
  int          beats_seen = 0;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // AXI4 read slave: one burst at a time, rvalid held high while a burst is open.
  bit          r_active = 1'b0;
  logic [31:0] r_addr = '0;
  int          r_left = 0;
  bit          s_rst, s_ar, s_r;
  logic [31:0] s_addr;
  logic [7:0]  s_len;

  initial begin
    mem.arready = 1'b0; mem.rvalid = 1'b0; mem.rdata = '0; mem.rresp = 2'b00;
    mem.rlast = 1'b0;   mem.rid = '0;      mem.awready = 1'b0; mem.wready = 1'b0;
    mem.bvalid = 1'b0;  mem.bresp = 2'b00; mem.bid = '0;      pkt.tready = 1'b0;
    forever begin
      @(negedge clk);
      s_rst  = rst;
      s_ar   = mem.arvalid && mem.arready;
      s_r    = mem.rvalid && mem.rready;
      s_addr = mem.araddr;
      s_len  = mem.arlen;
      @(posedge clk);
      #1;
      if (s_rst) begin
        r_active = 1'b0;
      end else begin
        if (s_r) begin
          r_addr = r_addr + 32'd8;
          r_left = r_left - 1;
          if (r_left == 0) r_active = 1'b0;
        end
        if (s_ar) begin
          r_active = 1'b1;
          r_addr   = s_addr;
          r_left   = int'(s_len) + 1;
        end
      end
      mem.arready = !r_active;
      mem.rvalid  = r_active;
      mem.rdata   = r_active ? mem_word(r_addr) : '0;
      mem.rlast   = r_active && (r_left == 1);
      mem.rresp   = (r_active && r_addr == err_addr) ? 2'b10 : 2'b00;
      pkt.tready  = ($urandom_range(99) < tready_duty);
    end
  end

  // Monitor: compares every AR and stream handshake against the queues.
  initial begin
    beat_t e;
    ar_t   a;
    forever begin
      @(negedge clk);
      if (mem.arvalid === 1'b1 && mem.arready === 1'b1) begin
        if (ar_q.size() == 0) begin
          check_output("unexpected_ar", 64'(mem.araddr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          a = ar_q.pop_front();
          check_output("araddr", 64'(mem.araddr), 64'(a.addr));
          check_output("arlen", 64'(mem.arlen), 64'(a.len));
        end
      end
      if (mem.rvalid === 1'b1) begin
        check_output("rready_mirror", 64'(mem.rready), 64'(pkt.tready));
      end
      if (pkt.tvalid === 1'b1 && pkt.tready === 1'b1) begin
        if (beat_q.size() == 0) begin
          check_output("unexpected_beat", pkt.tdata, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = beat_q.pop_front();
          if (e.user) exp_err = 1'b0;
          check_output("tdata", pkt.tdata, e.data);
          check_output("sideband", 64'({pkt.tlast, pkt.tuser, pkt.tkeep, pkt.tstrb}),
                       64'({e.last, e.user, e.strb, e.strb}));
          check_output("err_o", 64'(err), 64'(exp_err));
          if (ERR_EN && mem.rresp != 2'b00) exp_err = 1'b1;
        end
        beats_seen++;
      end
    end
  end

  task automatic push_ar(input logic [31:0] a, input logic [7:0] len);
    ar_t t;
    t.addr = a;
    t.len  = len;
    ar_q.push_back(t);
  endtask

  task automatic apply_stimulus(input logic [31:0] drive_addr, input logic [31:0] base,
                                input logic [13:0] size, input int nwords,
                                input logic [7:0] last_strb);
    beat_t b;
    for (int i = 0; i < nwords; i++) begin
      b.data = mem_word(base + 32'(i * 8));
      b.strb = (i == nwords - 1) ? last_strb : 8'hFF;
      b.last = (i == nwords - 1);
      b.user = (i == 0);
      beat_q.push_back(b);
    end
    @(posedge clk); #1;
    start = 1'b1; addr = drive_addr; pkt_size = size;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((busy || beat_q.size() != 0 || ar_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output({name, "_timeout"}, 64'(n >= budget), 64'd0);
  endtask

  initial begin
    int n;
    int base;
    rst = 1'b1; start = 1'b0; pkt_size = '0; addr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_err", 64'(err), 64'd0);
    check_output("rst_arvalid", 64'(mem.arvalid), 64'd0);
    check_output("rst_araddr", 64'(mem.araddr), 64'd0);
    check_output("rst_arlen", 64'(mem.arlen), 64'd0);
    check_output("rst_rready", 64'(mem.rready), 64'd0);
    check_output("rst_tvalid", 64'(pkt.tvalid), 64'd0);

    // Zero-size start must be ignored.
    @(posedge clk); #1;
    start = 1'b1; addr = 32'h100; pkt_size = 14'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_output("size0_busy", 64'(busy), 64'd0);

    // Single 8-beat burst; a second start while busy is ignored.
    push_ar(32'h1000, 8'd7);
    apply_stimulus(32'h1000, 32'h1000, 14'd64, 8, 8'hFF);
    @(posedge clk); #1;
    start = 1'b1; addr = 32'h9000; pkt_size = 14'd64;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("single", 200);

    // 257 words with a 2-byte tail: full burst then a single-beat burst.
    push_ar(32'h0, 8'd255);
    push_ar(32'h800, 8'd0);
    apply_stimulus(32'h0, 32'h0, 14'd2050, 257, 8'h03);
    wait_done("tail", 1000);

    // Split at the 4KB boundary.
    push_ar(32'hF80, 8'd15);
    push_ar(32'h1000, 8'd15);
    apply_stimulus(32'hF80, 32'hF80, 14'd256, 32, 8'hFF);
    wait_done("page", 300);

    // 512 beats under 30% tready.
    tready_duty = 30;
    push_ar(32'h2000, 8'd255);
    push_ar(32'h2800, 8'd255);
    apply_stimulus(32'h2000, 32'h2000, 14'd4096, 512, 8'hFF);
    wait_done("backpressure", 8000);
    tready_duty = 100;

    // SLVERR on beat 3 of 8.
    err_addr = 32'h3010;
    push_ar(32'h3000, 8'd7);
    apply_stimulus(32'h3000, 32'h3000, 14'd64, 8, 8'hFF);
    wait_done("rresp", 200);
    repeat (3) @(negedge clk);
    check_output("err_sticky", 64'(err), 64'(ERR_EN));
    err_addr = 32'hFFFF_FFFF;

    // Unaligned address is aligned down; 13 bytes -> 2 words, 5-byte tail.
    push_ar(32'h6000, 8'd1);
    apply_stimulus(32'h6003, 32'h6000, 14'd13, 2, 8'h1F);
    wait_done("unaligned", 100);

    // Reset in the middle of a 256-beat burst.
    push_ar(32'h4000, 8'd255);
    apply_stimulus(32'h4000, 32'h4000, 14'd2048, 256, 8'hFF);
    base = beats_seen;
    n = 0;
    while (beats_seen < base + 100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_output("beat100_timeout", 64'(n >= 1000), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    beat_q.delete();
    ar_q.delete();
    #1;
    check_output("midrst_arvalid", 64'(mem.arvalid), 64'd0);
    check_output("midrst_rready", 64'(mem.rready), 64'd0);
    check_output("midrst_busy", 64'(busy), 64'd0);
    check_output("midrst_tvalid", 64'(pkt.tvalid), 64'd0);

    push_ar(32'h5000, 8'd0);
    apply_stimulus(32'h5000, 32'h5000, 14'd8, 1, 8'hFF);
    wait_done("after_reset", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
